sr04_meas_ctrl: RTL and testbench
=================================

// Module: sr04_meas_ctrl
// PURPOSE
//  Sequences one HC-SR04 ranging cycle: trigger pulse, wait for echo, measure echo width, hold off.
//  Time base is a 1-cycle TICK_US strobe (1 us period) from the even clock divider/tick generator.
//  Sits between the divider and the distance/display logic in the SR04 top.
//  Outputs the echo width in microseconds with a one-cycle valid strobe, or a timeout flag.
// PARAMETERS
//  TRIG_US     10     trigger high time, in TICK_US strobes
//  TIMEOUT_US  30000  max wait for echo rise, and max echo width, in ticks
//  HOLDOFF_US  60000  dead time after each measurement before next trigger, in ticks
//  CNT_W       16     width of internal counter and ECHO_US; must hold HOLDOFF_US
// PORTS
//  CLK         in   1      system clock
//  RST         in   1      asynchronous reset, active-high
//  TICK_US     in   1      1-cycle strobe every microsecond, synchronous to CLK
//  START       in   1      single-shot request, sampled in IDLE only
//  AUTO_EN     in   1      1 = re-trigger automatically after each HOLDOFF
//  ECHO        in   1      sensor echo pin, asynchronous to CLK
//  TRIG        out  1      sensor trigger pin, registered
//  BUSY        out  1      1 in any state other than IDLE
//  DIST_VALID  out  1      1-cycle strobe: ECHO_US updated with a good measurement
//  ECHO_US     out  CNT_W  last measured echo width in us; holds until next update
//  TIMEOUT_ERR out  1      1-cycle strobe: no echo rise, or echo exceeded TIMEOUT_US
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE, cnt=0, TRIG=0, BUSY=0, DIST_VALID=0, ECHO_US=0,
//   TIMEOUT_ERR=0, sync flops=0. Reset mid-cycle drops TRIG immediately and aborts without a strobe.
//  ECHO passes a 2-flop synchroniser plus an edge detector (rise/fall are 1-cycle pulses).
//   ECHO-to-edge latency is 3 CLK cycles.
//  cnt increments only on TICK_US. It clears to 0 on every state transition.
//  States:
//   IDLE: go to TRIG if START=1 or AUTO_EN=1. TRIG goes high on the next cycle.
//   TRIG: TRIG=1. When cnt==TRIG_US-1 and TICK_US=1, go to WAIT_RISE and drop TRIG.
//     TRIG therefore spans exactly TRIG_US ticks, +/-1 tick of phase.
//   WAIT_RISE: on a rise edge, go to MEASURE.
//     If instead cnt==TIMEOUT_US-1 and TICK_US=1, pulse TIMEOUT_ERR, keep ECHO_US, go to HOLDOFF.
//     A rise in the same cycle as the timeout wins.
//   MEASURE: on a fall edge, ECHO_US<=cnt, pulse DIST_VALID, go to HOLDOFF.
//     A TICK_US in the fall cycle is not counted.
//     If cnt==TIMEOUT_US-1 and TICK_US=1 with no fall: ECHO_US<=TIMEOUT_US (saturated),
//     pulse TIMEOUT_ERR, no DIST_VALID, go to HOLDOFF.
//   HOLDOFF: when cnt==HOLDOFF_US-1 and TICK_US=1, go to IDLE.
//  Request handling:
//   START outside IDLE is ignored; no queueing.
//   AUTO_EN=1 gives back-to-back cycles with one IDLE cycle between them.
//   Clearing AUTO_EN finishes the current cycle, then the block stops in IDLE.
//  Edges outside WAIT_RISE/MEASURE are ignored. This covers echo already high at trigger end:
//   no rise edge is seen, so the result is a timeout.
//  DIST_VALID and TIMEOUT_ERR are never high in the same cycle.
//  Counter compares are equality on CNT_W bits. No wrap is possible because parameters < 2**CNT_W.
// STRUCTURE
//  Package sr04_pkg:
//   state enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF, 3 bits);
//   default TRIG_US/TIMEOUT_US/HOLDOFF_US constants; CNT_W.
//  Sub-module sr04_echo_sync: 2FF synchroniser + rise/fall pulse detector
//   (CLK, RST, D -> Q, RISE, FALL).
//  Top: one FSM always block, one counter, output registers.
// TESTING  (TICK_US every 4 CLK; bench uses TRIG_US=10, TIMEOUT_US=200, HOLDOFF_US=50)
//  Normal: START pulse, ECHO high 120 ticks after TRIG falls
//   -> TRIG high 10 ticks; DIST_VALID once; ECHO_US=120 (+/-1); TIMEOUT_ERR=0.
//  No echo: START, ECHO held 0 -> TIMEOUT_ERR once at 200 ticks after TRIG fall;
//   ECHO_US unchanged; BUSY falls 50 ticks later.
//  Stuck echo: ECHO rises and stays high -> TIMEOUT_ERR once; ECHO_US=200; no DIST_VALID.
//  AUTO_EN=1 for 3 cycles with echo=30 ticks -> 3 DIST_VALID pulses, each ECHO_US=30;
//   clear AUTO_EN mid-cycle -> exactly one more result, then IDLE.
//  START asserted while BUSY -> ignored: one TRIG pulse only.
//   Assert RST during MEASURE -> TRIG=0, BUSY=0, ECHO_US=0 in the same cycle; no strobes.
//  ECHO glitch in HOLDOFF or IDLE -> no state change and no output strobes.

Source files
------------

// File: rtl/sr04_pkg.sv
// Shared types and default timing constants for the HC-SR04 ranging controller.
package sr04_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int TRIG_US_DEF    = 10;
  localparam int TIMEOUT_US_DEF = 30000;
  localparam int HOLDOFF_US_DEF = 60000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

endpackage

// File: rtl/sr04_echo_sync.sv
// Two-flop synchroniser for the asynchronous ECHO pin plus registered rise/fall pulses.
// D-to-RISE/FALL latency is three CLK cycles.
module sr04_echo_sync (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q,
  output logic RISE,
  output logic FALL
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      RISE   <= 1'b0;
      FALL   <= 1'b0;
    end else begin
      meta   <= D;
      sync   <= meta;
      sync_d <= sync;
      RISE   <= sync & ~sync_d;
      FALL   <= ~sync & sync_d;
    end
  end

  assign Q = sync;

endmodule

// File: rtl/sr04_meas_ctrl.sv
// One HC-SR04 ranging cycle: trigger pulse, wait for echo, measure echo width, hold off.
// All timing is counted in TICK_US strobes; DBG_STATE/DBG_ECHO expose the FSM and synced echo.
module sr04_meas_ctrl
  import sr04_pkg::*;
#(
  parameter int TRIG_US    = TRIG_US_DEF,
  parameter int TIMEOUT_US = TIMEOUT_US_DEF,
  parameter int HOLDOFF_US = HOLDOFF_US_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK_US,
  input  logic             START,
  input  logic             AUTO_EN,
  input  logic             ECHO,
  output logic             TRIG,
  output logic             BUSY,
  output logic             DIST_VALID,
  output logic [CNT_W-1:0] ECHO_US,
  output logic             TIMEOUT_ERR,
  output state_t           DBG_STATE,
  output logic             DBG_ECHO
);

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_SAT  = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_US - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] echo_us_nxt;
  logic             trig_nxt, valid_nxt, tmo_nxt;
  logic             echo_rise, echo_fall;

  sr04_echo_sync u_echo_sync (
    .CLK  (CLK),
    .RST  (RST),
    .D    (ECHO),
    .Q    (DBG_ECHO),
    .RISE (echo_rise),
    .FALL (echo_fall)
  );

  // Result interface: DIST_VALID and TIMEOUT_ERR are single-cycle, mutually exclusive strobes
  // with no back-pressure; ECHO_US is valid in the strobe cycle and holds until the next update.
  always_comb begin
    state_nxt   = state;
    trig_nxt    = 1'b0;
    valid_nxt   = 1'b0;
    tmo_nxt     = 1'b0;
    echo_us_nxt = ECHO_US;
    unique case (state)
      ST_IDLE: begin
        if (START || AUTO_EN) begin
          state_nxt = ST_TRIG;
          trig_nxt  = 1'b1;
        end
      end
      ST_TRIG: begin
        trig_nxt = 1'b1;
        if (TICK_US && cnt == TRIG_LAST) begin
          state_nxt = ST_WAIT_RISE;
          trig_nxt  = 1'b0;
        end
      end
      ST_WAIT_RISE: begin
        // A rise arriving together with the timeout tick takes priority.
        if (echo_rise) begin
          state_nxt = ST_MEASURE;
        end else if (TICK_US && cnt == TIMEOUT_LAST) begin
          tmo_nxt   = 1'b1;
          state_nxt = ST_HOLDOFF;
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          echo_us_nxt = cnt;
          valid_nxt   = 1'b1;
          state_nxt   = ST_HOLDOFF;
        end else if (TICK_US && cnt == TIMEOUT_LAST) begin
          echo_us_nxt = TIMEOUT_SAT;
          tmo_nxt     = 1'b1;
          state_nxt   = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (TICK_US && cnt == HOLDOFF_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;
    else if (TICK_US)       cnt_nxt = cnt + 1'b1;
    else                    cnt_nxt = cnt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      TRIG        <= 1'b0;
      DIST_VALID  <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      ECHO_US     <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      TRIG        <= trig_nxt;
      DIST_VALID  <= valid_nxt;
      TIMEOUT_ERR <= tmo_nxt;
      ECHO_US     <= echo_us_nxt;
    end
  end

  assign BUSY      = (state != ST_IDLE);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_sr04_meas_ctrl.sv
// Bench for sr04_meas_ctrl: table of single shots plus hand sequences for timing, auto mode,
// request overlap, echo glitches and asynchronous reset.
module tb_sr04_meas_ctrl;
  import sr04_pkg::*;

  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 200;
  localparam int HOLDOFF_US = 50;
  localparam int CNT_W      = 16;
  localparam int LIMIT      = 3000;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             TICK_US = 1'b0;
  logic             START = 1'b0;
  logic             AUTO_EN = 1'b0;
  logic             ECHO = 1'b0;
  logic             TRIG, BUSY, DIST_VALID, TIMEOUT_ERR, DBG_ECHO;
  logic [CNT_W-1:0] ECHO_US;
  state_t           DBG_STATE;

  int checks = 0;
  int failures = 0;
  int trig_rises = 0;
  int exp_trigs = 0;
  logic [CNT_W:0] exp_q[$];  // MSB set: timeout strobe expected, low bits: ECHO_US

  typedef struct {
    int    delay;    // ticks from TRIG fall to ECHO rise
    int    width;    // echo ticks; 0 = no echo, -1 = stuck high
    bit    exp_tmo;
    int    exp_val;
    string name;
  } shot_t;

  shot_t shots[6];

  sr04_meas_ctrl #(
    .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US), .HOLDOFF_US(HOLDOFF_US), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .TICK_US(TICK_US), .START(START), .AUTO_EN(AUTO_EN), .ECHO(ECHO),
    .TRIG(TRIG), .BUSY(BUSY), .DIST_VALID(DIST_VALID), .ECHO_US(ECHO_US),
    .TIMEOUT_ERR(TIMEOUT_ERR), .DBG_STATE(DBG_STATE), .DBG_ECHO(DBG_ECHO)
  );

  // ---------------- clock / tick ----------------
  always #5 CLK = ~CLK;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(posedge CLK);
      #1;
      div = (div == 3) ? 0 : div + 1;
      TICK_US = (div == 3);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * 4) step();
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic wait_trig_fall();
    int n;
    n = 0;
    while (!TRIG && n < LIMIT) begin step(); n++; end
    while (TRIG && n < LIMIT) begin step(); n++; end
    check(n < LIMIT, "wait_trig_fall_bound", n, LIMIT);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < LIMIT) begin step(); n++; end
    check(n < LIMIT, "wait_idle_bound", n, LIMIT);
  endtask

  task automatic wait_state(input state_t s);
    int n;
    n = 0;
    while (DBG_STATE != s && n < LIMIT) begin step(); n++; end
    check(n < LIMIT, "wait_state_bound", n, LIMIT);
  endtask

  task automatic run_shot(input shot_t s);
    exp_q.push_back({s.exp_tmo, CNT_W'(s.exp_val)});
    exp_trigs++;
    pulse_start();
    wait_trig_fall();
    wait_ticks(s.delay);
    if (s.width != 0) ECHO = 1'b1;
    if (s.width > 0) begin
      wait_ticks(s.width);
      ECHO = 1'b0;
    end
    wait_idle();
    ECHO = 1'b0;
    step();
    check(exp_q.size() == 0, {"result_seen_", s.name}, exp_q.size(), 0);
    check(trig_rises == exp_trigs, {"trig_count_", s.name}, trig_rises, exp_trigs);
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic           trig_prev;
    int             trig_len;
    logic [CNT_W:0] e;
    int             act, want;
    trig_prev = 1'b0;
    trig_len  = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        trig_prev = 1'b0;
        trig_len  = 0;
      end else begin
        if (DIST_VALID || TIMEOUT_ERR) begin
          check(!(DIST_VALID && TIMEOUT_ERR), "strobe_exclusive", {DIST_VALID, TIMEOUT_ERR}, 0);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_strobe", {DIST_VALID, TIMEOUT_ERR}, 0);
          end else begin
            e    = exp_q.pop_front();
            act  = int'(ECHO_US);
            want = int'(e[CNT_W-1:0]);
            if (e[CNT_W]) begin
              check(TIMEOUT_ERR && !DIST_VALID, "strobe_kind_timeout", TIMEOUT_ERR, 1);
              check(act == want, "timeout_echo_us", act, want);
            end else begin
              check(DIST_VALID && !TIMEOUT_ERR, "strobe_kind_valid", DIST_VALID, 1);
              check(act >= want - 1 && act <= want + 1, "echo_us_pm1", act, want);
            end
          end
        end
        if (TRIG) trig_len++;
        if (TRIG && !trig_prev) trig_rises++;
        if (!TRIG && trig_prev) begin
          check(trig_len >= 36 && trig_len <= 44, "trig_width_cycles", trig_len, 40);
          trig_len = 0;
        end
        trig_prev = TRIG;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    shots[0] = '{delay: 0,   width: 0,   exp_tmo: 1'b1, exp_val: 0,   name: "no_echo_after_reset"};
    shots[1] = '{delay: 5,   width: 120, exp_tmo: 1'b0, exp_val: 120, name: "normal_120"};
    shots[2] = '{delay: 1,   width: 5,   exp_tmo: 1'b0, exp_val: 5,   name: "short_5"};
    shots[3] = '{delay: 150, width: 30,  exp_tmo: 1'b0, exp_val: 30,  name: "late_30"};
    shots[4] = '{delay: 20,  width: 190, exp_tmo: 1'b0, exp_val: 190, name: "long_190"};
    shots[5] = '{delay: 10,  width: -1,  exp_tmo: 1'b1, exp_val: 200, name: "stuck_echo"};

    // Reset state
    repeat (3) step();
    check(TRIG == 1'b0,        "rst_trig",    TRIG, 0);
    check(BUSY == 1'b0,        "rst_busy",    BUSY, 0);
    check(DIST_VALID == 1'b0,  "rst_valid",   DIST_VALID, 0);
    check(TIMEOUT_ERR == 1'b0, "rst_timeout", TIMEOUT_ERR, 0);
    check(ECHO_US == '0,       "rst_echo_us", ECHO_US, 0);
    check(DBG_STATE == ST_IDLE, "rst_state",  DBG_STATE, ST_IDLE);
    RST = 1'b0;
    repeat (5) step();
    check(BUSY == 1'b0, "idle_without_request", BUSY, 0);

    // Table of single shots
    for (int i = 0; i < 6; i++) run_shot(shots[i]);

    // No-echo timing; ECHO_US must keep the saturated 200 from the stuck shot
    exp_q.push_back({1'b1, CNT_W'(200)});
    exp_trigs++;
    pulse_start();
    wait_trig_fall();
    n = 0;
    while (!TIMEOUT_ERR && n < LIMIT) begin step(); n++; end
    check(n >= 796 && n <= 804, "timeout_latency_cycles", n, 800);
    n = 0;
    while (BUSY && n < LIMIT) begin step(); n++; end
    check(n >= 196 && n <= 204, "holdoff_cycles", n, 200);
    check(exp_q.size() == 0, "no_echo_result_seen", exp_q.size(), 0);

    // START while busy is ignored
    exp_q.push_back({1'b0, CNT_W'(40)});
    exp_trigs++;
    pulse_start();
    repeat (8) step();
    pulse_start();
    wait_trig_fall();
    pulse_start();
    wait_ticks(10);
    ECHO = 1'b1;
    wait_ticks(5);
    pulse_start();
    wait_ticks(35);
    ECHO = 1'b0;
    wait_state(ST_HOLDOFF);
    pulse_start();
    wait_idle();
    repeat (20) step();
    check(trig_rises == exp_trigs, "busy_start_one_trig", trig_rises, exp_trigs);
    check(DBG_STATE == ST_IDLE, "busy_start_back_idle", DBG_STATE, ST_IDLE);
    check(exp_q.size() == 0, "busy_start_result_seen", exp_q.size(), 0);

    // Auto re-trigger, cleared during the fourth cycle
    AUTO_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, CNT_W'(30)});
      exp_trigs++;
      wait_trig_fall();
      wait_ticks(20);
      ECHO = 1'b1;
      if (i == 3) AUTO_EN = 1'b0;
      wait_ticks(30);
      ECHO = 1'b0;
      if (i < 3) begin
        wait_idle();
        n = 0;
        while (!BUSY && n < 100) begin step(); n++; end
        check(n == 1, "auto_idle_gap_cycles", n, 1);
      end
    end
    wait_idle();
    wait_ticks(50);
    check(trig_rises == exp_trigs, "auto_trig_count", trig_rises, exp_trigs);
    check(DBG_STATE == ST_IDLE, "auto_stops_idle", DBG_STATE, ST_IDLE);
    check(exp_q.size() == 0, "auto_results_seen", exp_q.size(), 0);

    // Echo glitches in HOLDOFF and IDLE
    exp_q.push_back({1'b0, CNT_W'(25)});
    exp_trigs++;
    pulse_start();
    wait_trig_fall();
    wait_ticks(5);
    ECHO = 1'b1;
    wait_ticks(25);
    ECHO = 1'b0;
    wait_state(ST_HOLDOFF);
    repeat (10) step();
    ECHO = 1'b1;
    repeat (3) step();
    check(DBG_ECHO == 1'b1, "glitch_reaches_sync", DBG_ECHO, 1);
    ECHO = 1'b0;
    repeat (10) step();
    check(DBG_STATE == ST_HOLDOFF, "holdoff_glitch_state", DBG_STATE, ST_HOLDOFF);
    wait_idle();
    ECHO = 1'b1;
    repeat (6) step();
    ECHO = 1'b0;
    repeat (20) step();
    check(DBG_STATE == ST_IDLE, "idle_glitch_state", DBG_STATE, ST_IDLE);
    check(trig_rises == exp_trigs, "glitch_trig_count", trig_rises, exp_trigs);
    check(exp_q.size() == 0, "glitch_results_seen", exp_q.size(), 0);

    // Asynchronous reset during MEASURE
    exp_trigs++;
    pulse_start();
    wait_trig_fall();
    wait_ticks(3);
    ECHO = 1'b1;
    wait_ticks(10);
    check(DBG_STATE == ST_MEASURE, "pre_reset_measure", DBG_STATE, ST_MEASURE);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check(TRIG == 1'b0,   "async_rst_trig",    TRIG, 0);
    check(BUSY == 1'b0,   "async_rst_busy",    BUSY, 0);
    check(ECHO_US == '0,  "async_rst_echo_us", ECHO_US, 0);
    ECHO = 1'b0;
    repeat (2) step();
    RST = 1'b0;
    repeat (30) step();
    check(DBG_STATE == ST_IDLE, "post_reset_idle", DBG_STATE, ST_IDLE);

    // Asynchronous reset during TRIG drops the pin at once
    exp_trigs++;
    pulse_start();
    n = 0;
    while (!TRIG && n < 100) begin step(); n++; end
    check(TRIG == 1'b1, "trig_before_reset", TRIG, 1);
    repeat (5) step();
    #2;
    RST = 1'b1;
    #1;
    check(TRIG == 1'b0, "async_rst_trig_drop", TRIG, 0);
    repeat (2) step();
    RST = 1'b0;
    repeat (30) step();
    check(trig_rises == exp_trigs, "reset_trig_count", trig_rises, exp_trigs);
    check(exp_q.size() == 0, "reset_no_strobes", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
